multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle control FSM for the 10-instruction core ISA: rtype, addi, lw, sw, beq, bne, slti, andi, ori, li.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared memory and ALU.
//  Supports a variable-latency memory handshake with timeout, a global stall, and illegal-opcode trapping.
//  Sits between the instruction register and the datapath muxes/enables.
// PARAMETERS
//  OPCODE_W     6   opcode width; encodings 0..9 = rtype,addi,lw,sw,beq,bne,slti,andi,ori,li; all else illegal
//  ALUOP_W      3   alu_op width (>=3); codes zero-extended
//  MEM_TIMEOUT  16  max wait cycles for mem_ready in FETCH/MEM before trap (>=1)
// PORTS
//  clk            in   1         clock, rising edge
//  rst_n          in   1         asynchronous active-low reset
//  opcode         in   OPCODE_W  opcode field of instruction register
//  mem_ready      in   1         memory access complete this cycle
//  stall          in   1         hold FSM and suppress all write enables
//  pc_write       out  1         unconditional PC update
//  pc_write_cond  out  1         PC update if branch condition true
//  branch_ne      out  1         1: branch on ALU nonzero (bne); 0: on zero (beq)
//  pc_src         out  1         0: ALU result; 1: ALUOut register
//  i_or_d         out  1         memory address: 0 = PC, 1 = ALUOut
//  ir_write       out  1         load instruction register
//  mem_read       out  1         memory read request
//  mem_write      out  1         memory write request
//  mem_to_reg     out  1         register write data from MDR
//  reg_dst        out  1         destination register = rd (rtype)
//  reg_write      out  1         register file write enable
//  alu_src_a      out  1         0: PC, 1: reg A
//  alu_src_b      out  2         00: reg B, 01: const 4, 10: sext imm, 11: sext imm<<2
//  alu_op         out  ALUOP_W   0 funct, 1 add, 2 sub, 3 slt, 4 and, 5 or, 6 pass-B
//  illegal        out  1         sticky: illegal opcode trapped
//  timeout        out  1         sticky: memory timeout trapped
//  state          out  3         0 RST, 1 FETCH, 2 DECODE, 3 EXEC, 4 MEM, 5 WB, 6 BRANCH, 7 TRAP
// BEHAVIOUR
//  - rst_n low (async): state=RST, wait counter=0, illegal=timeout=0.
//    In RST all outputs are 0. First clk edge after release moves the FSM to FETCH.
//  - Outputs are Moore-style: decoded from state and opcode. opcode is sampled in DECODE and held internally until the next FETCH.
//  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=0.
//    Only in the mem_ready cycle: ir_write=1, pc_write=1, then go to DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=add (branch target).
//    Next state: beq/bne -> BRANCH, legal -> EXEC, illegal -> TRAP with illegal=1.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=1, pc_write_cond=1, branch_ne=(bne). Then -> FETCH.
//  - EXEC: alu_src_a=1. Operand select and alu_op per instruction:
//      rtype: b=00, funct.  addi/lw/sw: b=10, add.  slti: b=10, slt.
//      andi: b=10, and.  ori: b=10, or.  li: b=10, pass-B.
//    Then lw/sw -> MEM, otherwise -> WB.
//  - MEM: i_or_d=1. lw drives mem_read, sw drives mem_write, both held until mem_ready.
//    On mem_ready: lw -> WB, sw -> FETCH.
//  - WB: reg_write=1, reg_dst=(rtype), mem_to_reg=(lw). Then -> FETCH.
//  - Latency without waits: branch 3 cycles; rtype, imm-ALU, li and sw 4 cycles; lw 5 cycles.
//    Each wait cycle adds 1.
//  - Wait counter: cleared on entering FETCH/MEM and on mem_ready; +1 per cycle waiting with mem_ready=0.
//    Reaching MEM_TIMEOUT -> TRAP with timeout=1 set on that edge.
//    mem_ready in the same cycle as the count limit wins: no trap.
//  - stall=1: state and counter frozen; pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read forced 0.
//    mem_ready is ignored while stalled.
//  - TRAP: all control outputs 0, flags held, exit only by reset.
//  - Reset asserted mid-instruction: immediate return to RST; no partial write enable survives.
// TESTING
//  - Reset, then rtype (op 0), mem_ready=1 always -> states 1,2,3,5,1; reg_write=1 and reg_dst=1 only in WB.
//  - lw (op 2), mem_ready low 3 cycles in MEM -> mem_read held 4 cycles; WB has mem_to_reg=1; total 8 cycles.
//  - bne (op 5) -> 3 cycles; BRANCH has pc_write_cond=1, branch_ne=1, alu_op=2, pc_src=1.
//  - opcode 6'h3F in DECODE -> state 7, illegal=1, all enables 0 until rst_n pulse.
//  - MEM_TIMEOUT=4, FETCH with mem_ready=0 -> TRAP after 4 wait cycles, timeout=1;
//    repeat with mem_ready on 4th cycle -> DECODE, no trap.
//  - sw (op 3) with stall=1 for 2 cycles in MEM, then rst_n low mid-EXEC on next op
//    -> mem_write=0 while stalled; state=0 immediately on reset.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 10-instruction core ISA.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB (or BRANCH) over a
// shared memory and ALU, with a mem_ready handshake guarded by a wait-cycle
// timeout, a global stall, and sticky illegal-opcode / timeout traps.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   opcode               opcode field of the instruction register
//   mem_ready            memory access completes this cycle
//   stall                freeze FSM and wait counter, suppress write enables
//   pc_write .. alu_op   datapath mux selects and write enables
//   illegal, timeout     sticky trap flags
//   state                current FSM state (0 RST .. 7 TRAP)
module multicycle_controller #(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                stall,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic                pc_src,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                illegal,
  output logic                timeout,
  output logic [2:0]          state
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_LI    = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_COUNT = OPCODE_W'(10);

  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_PASSB = ALUOP_W'(6);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    wait_cnt;
  logic [OPCODE_W-1:0] op_q;
  logic                illegal_q;
  logic                timeout_q;

  assign state   = state_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

  // State, wait counter, held opcode and sticky flags; everything freezes under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      wait_cnt  <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        S_RST: begin
          state_q  <= S_FETCH;
          wait_cnt <= '0;
        end
        S_FETCH: begin
          // A ready in the limit cycle completes the access rather than trapping.
          if (mem_ready) begin
            state_q  <= S_DECODE;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_LAST) begin
            state_q   <= S_TRAP;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          op_q <= opcode;
          if (opcode == OP_BEQ || opcode == OP_BNE) begin
            state_q <= S_BRANCH;
          end else if (opcode < OP_COUNT) begin
            state_q <= S_EXEC;
          end else begin
            state_q   <= S_TRAP;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (op_q == OP_LW || op_q == OP_SW) begin
            state_q  <= S_MEM;
            wait_cnt <= '0;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            state_q  <= (op_q == OP_LW) ? S_WB : S_FETCH;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_LAST) begin
            state_q   <= S_TRAP;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_WB, S_BRANCH: begin
          state_q  <= S_FETCH;
          wait_cnt <= '0;
        end
        S_TRAP: state_q <= S_TRAP;
        default: state_q <= S_TRAP;
      endcase
    end
  end

  // Moore decode of state and held opcode; stall masks every write/request enable.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_FUNCT;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_src        = 1'b1;
        pc_write_cond = 1'b1;
        branch_ne     = (op_q == OP_BNE);
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op_q)
          OP_RTYPE: begin
            alu_src_b = 2'b00;
            alu_op    = ALU_FUNCT;
          end
          OP_SLTI: alu_op = ALU_SLT;
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          OP_LI:   alu_op = ALU_PASSB;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q == OP_RTYPE);
        mem_to_reg = (op_q == OP_LW);
      end
      default: ;
    endcase
    if (stall) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      mem_read      = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller (MEM_TIMEOUT = 4).
// Each instruction is expanded into a per-cycle list of expected state and
// control outputs from its phase sequence and wait counts; tests then replay
// the list against the DUT.
module tb_multicycle_controller;

  localparam int unsigned TMO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       stall;
  logic       pc_write, pc_write_cond, branch_ne, pc_src, i_or_d, ir_write;
  logic       mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       illegal, timeout;
  logic [2:0] state;
  logic [16:0] ctl;

  int vectors = 0;
  int miscompares = 0;

  multicycle_controller #(.OPCODE_W(6), .ALUOP_W(3), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .stall(stall),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_src(pc_src), .i_or_d(i_or_d), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal(illegal), .timeout(timeout), .state(state)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_write, pc_write_cond, branch_ne, pc_src, i_or_d, ir_write, mem_read,
                mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op};

  typedef struct {
    logic [2:0]  st;
    logic [16:0] ctl;
    logic        rdy;
    logic        stl;
    logic [5:0]  opc;
  } cyc_t;

  cyc_t q[$];

  function automatic logic [16:0] cv(input logic pw, pwc, bn, ps, iod, irw, mr, mw,
                                     m2r, rd, rw, sa, input logic [1:0] sb,
                                     input logic [2:0] op);
    return {pw, pwc, bn, ps, iod, irw, mr, mw, m2r, rd, rw, sa, sb, op};
  endfunction

  function automatic logic [16:0] fetch_c(input logic rdy, input logic stl);
    return cv(rdy && !stl, 1'b0, 1'b0, 1'b0, 1'b0, rdy && !stl, !stl, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd1);
  endfunction

  function automatic logic [16:0] mem_c(input logic [5:0] op, input logic stl);
    return cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (op == 6'd2) && !stl,
              (op == 6'd3) && !stl, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0);
  endfunction

  // ALU function used in EXEC for each legal opcode.
  function automatic logic [2:0] exec_alu(input logic [5:0] op);
    case (op)
      6'd0:    return 3'd0;
      6'd6:    return 3'd3;
      6'd7:    return 3'd4;
      6'd8:    return 3'd5;
      6'd9:    return 3'd6;
      default: return 3'd1;
    endcase
  endfunction

  function automatic void push(input logic [2:0] st, input logic [16:0] c,
                               input logic rdy, input logic stl, input logic [5:0] opc);
    cyc_t e;
    e.st = st; e.ctl = c; e.rdy = rdy; e.stl = stl; e.opc = opc;
    q.push_back(e);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom_range(0, 63));
  endfunction

  // Expected cycles of one legal instruction: fw/mw wait cycles before mem_ready.
  function automatic void build_trace(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(3'd1, fetch_c(1'b0, 1'b0), 1'b0, 1'b0, r6());
    push(3'd1, fetch_c(1'b1, 1'b0), 1'b1, 1'b0, r6());
    push(3'd2, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'd1), rb(), 1'b0, op);
    if (op == 6'd4 || op == 6'd5) begin
      push(3'd6, cv(0, 1, op == 6'd5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'd2), rb(), 1'b0, r6());
    end else begin
      push(3'd3, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, (op == 6'd0) ? 2'b00 : 2'b10,
                    exec_alu(op)), rb(), 1'b0, r6());
      if (op == 6'd2 || op == 6'd3) begin
        for (int i = 0; i < mw; i++) push(3'd4, mem_c(op, 1'b0), 1'b0, 1'b0, r6());
        push(3'd4, mem_c(op, 1'b0), 1'b1, 1'b0, r6());
      end
      if (op != 6'd3)
        push(3'd5, cv(0, 0, 0, 0, 0, 0, 0, 0, op == 6'd2, op == 6'd0, 1, 0, 2'b00, 3'd0),
             rb(), 1'b0, r6());
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; mem_ready = 1'b1; opcode = 6'd0;
    #1;
    vectors++;
    if ({state, ctl, illegal, timeout} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_asserted: state=%0d ctl=%05h ill=%b tmo=%b, expected all 0",
               state, ctl, illegal, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({state, ctl} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_released: state=%0d ctl=%05h, expected state=0 ctl=00000", state, ctl);
    end
  endtask

  task automatic test_rtype();
    cyc_t e;
    build_trace(6'd0, 0, 0);
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      opcode = e.opc; mem_ready = e.rdy; stall = e.stl;
      #1;
      vectors++;
      if ({state, ctl} !== {e.st, e.ctl}) begin
        miscompares++;
        $display("FAIL rtype: state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                 state, ctl, e.st, e.ctl);
      end
    end
  endtask

  task automatic test_lw_wait();
    cyc_t e;
    build_trace(6'd2, 0, 3);
    build_trace(6'd2, 1, TMO - 1);
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      opcode = e.opc; mem_ready = e.rdy; stall = e.stl;
      #1;
      vectors++;
      if ({state, ctl} !== {e.st, e.ctl}) begin
        miscompares++;
        $display("FAIL lw_wait: state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                 state, ctl, e.st, e.ctl);
      end
    end
  endtask

  task automatic test_branch();
    cyc_t e;
    build_trace(6'd5, 0, 0);
    build_trace(6'd4, 2, 0);
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      opcode = e.opc; mem_ready = e.rdy; stall = e.stl;
      #1;
      vectors++;
      if ({state, ctl} !== {e.st, e.ctl}) begin
        miscompares++;
        $display("FAIL branch: state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                 state, ctl, e.st, e.ctl);
      end
    end
  endtask

  task automatic test_illegal();
    cyc_t e;
    logic [5:0] bad;
    for (int k = 0; k < 2; k++) begin
      bad = (k == 0) ? 6'h3F : 6'($urandom_range(10, 62));
      do_reset();
      push(3'd1, fetch_c(1'b1, 1'b0), 1'b1, 1'b0, r6());
      push(3'd2, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'd1), rb(), 1'b0, bad);
      for (int i = 0; i < 4; i++) push(3'd7, 17'd0, rb(), 1'b0, r6());
      while (q.size() > 0) begin
        e = q.pop_front();
        @(negedge clk);
        opcode = e.opc; mem_ready = e.rdy; stall = e.stl;
        #1;
        vectors++;
        if ({state, ctl} !== {e.st, e.ctl}) begin
          miscompares++;
          $display("FAIL illegal op=%0d: state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                   bad, state, ctl, e.st, e.ctl);
        end
      end
      vectors++;
      if ({illegal, timeout} !== 2'b10) begin
        miscompares++;
        $display("FAIL illegal_flags: ill=%b tmo=%b, expected ill=1 tmo=0", illegal, timeout);
      end
    end
    do_reset();
    #1;
    vectors++;
    if ({illegal, state} !== 4'd0) begin
      miscompares++;
      $display("FAIL illegal_cleared: ill=%b state=%0d, expected ill=0 state=0", illegal, state);
    end
  endtask

  task automatic test_timeout();
    cyc_t e;
    // FETCH trap, MEM trap (sw), then ready exactly in the limit cycle.
    for (int k = 0; k < 3; k++) begin
      do_reset();
      if (k == 0) begin
        for (int i = 0; i < TMO; i++) push(3'd1, fetch_c(1'b0, 1'b0), 1'b0, 1'b0, r6());
        for (int i = 0; i < 2; i++) push(3'd7, 17'd0, 1'b1, 1'b0, r6());
      end else if (k == 1) begin
        build_trace(6'd3, 0, 0);
        void'(q.pop_back());
        for (int i = 0; i < TMO; i++) push(3'd4, mem_c(6'd3, 1'b0), 1'b0, 1'b0, r6());
        for (int i = 0; i < 2; i++) push(3'd7, 17'd0, 1'b1, 1'b0, r6());
      end else begin
        build_trace(6'd1, TMO - 1, 0);
      end
      while (q.size() > 0) begin
        e = q.pop_front();
        @(negedge clk);
        opcode = e.opc; mem_ready = e.rdy; stall = e.stl;
        #1;
        vectors++;
        if ({state, ctl} !== {e.st, e.ctl}) begin
          miscompares++;
          $display("FAIL timeout case%0d: state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                   k, state, ctl, e.st, e.ctl);
        end
      end
      vectors++;
      if ({illegal, timeout} !== {1'b0, k != 2}) begin
        miscompares++;
        $display("FAIL timeout_flags case%0d: ill=%b tmo=%b, expected ill=0 tmo=%b",
                 k, illegal, timeout, k != 2);
      end
    end
  endtask

  task automatic test_stall();
    cyc_t e;
    do_reset();
    // Counter frozen at the limit while stalled, then ready completes the fetch.
    for (int i = 0; i < TMO - 1; i++) push(3'd1, fetch_c(1'b0, 1'b0), 1'b0, 1'b0, r6());
    for (int i = 0; i < 5; i++) push(3'd1, fetch_c(1'b0, 1'b1), 1'b0, 1'b1, r6());
    // sw with two stalled MEM cycles where mem_ready must be ignored.
    build_trace(6'd3, 0, 0);
    void'(q.pop_back());
    for (int i = 0; i < 2; i++) push(3'd4, mem_c(6'd3, 1'b1), 1'b1, 1'b1, r6());
    push(3'd4, mem_c(6'd3, 1'b0), 1'b1, 1'b0, r6());
    // Next addi: stalled fetch with mem_ready high, then run up to EXEC.
    push(3'd1, fetch_c(1'b1, 1'b1), 1'b1, 1'b1, r6());
    build_trace(6'd1, 0, 0);
    void'(q.pop_back());
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      opcode = e.opc; mem_ready = e.rdy; stall = e.stl;
      #1;
      vectors++;
      if ({state, ctl} !== {e.st, e.ctl}) begin
        miscompares++;
        $display("FAIL stall: state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                 state, ctl, e.st, e.ctl);
      end
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({state, ctl, timeout} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_mid_exec: state=%0d ctl=%05h tmo=%b, expected all 0",
               state, ctl, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    cyc_t e;
    logic [5:0] op;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      op = 6'($urandom_range(0, 9));
      build_trace(op, int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, TMO - 1)));
    end
    push(3'd1, fetch_c(1'b0, 1'b0), 1'b0, 1'b0, r6());
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      opcode = e.opc; mem_ready = e.rdy; stall = e.stl;
      #1;
      vectors++;
      if ({state, ctl} !== {e.st, e.ctl}) begin
        miscompares++;
        $display("FAIL random: state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                 state, ctl, e.st, e.ctl);
      end
    end
    vectors++;
    if ({illegal, timeout} !== 2'b00) begin
      miscompares++;
      $display("FAIL random_flags: ill=%b tmo=%b, expected 0 0", illegal, timeout);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
